multi_button_debouncer: RTL and testbench
=========================================

# multi_button_debouncer

Parametrised N-channel push-button front end that replaces the single-pair debouncer in the user-input path. Each raw button is synchronised and debounced independently. A debounced press generates a one-cycle event, and a held button can optionally generate auto-repeat events. All events are serialised onto a single valid/one-hot event bus that the downstream counter/control logic consumes.

## Interface
- N_BTN, 2: number of button channels, 1..16
- DEB_CYCLES, 100: consecutive stable synchronised cycles required to accept a level change, ≥1
- REPEAT_DELAY, 0: cycles from press acceptance to first repeat event; 0 disables auto-repeat
- REPEAT_PERIOD, 50: cycles between subsequent repeat events, ≥1; ignored if REPEAT_DELAY=0
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- btn_in  in  N_BTN  raw asynchronous button levels, 1 = pressed
- enable  in  1  1 = events allowed; 0 = events suppressed
- evt_valid  out  1  one-cycle event strobe
- evt_onehot  out  N_BTN  channel of current event, one-hot; bit0 = btn_in[0]
- evt_repeat  out  1  1 = current event is an auto-repeat, 0 = initial press
- btn_level  out  N_BTN  debounced level of each channel
- evt_drop  out  1  one-cycle strobe: an event was lost because its channel already had an event pending

## Operation
- Per channel, a 2-flop synchroniser produces sync[i]. A counter cnt[i] of width clog2(DEB_CYCLES+1) tracks stability.
  - Each edge where sync[i] != btn_level[i]: cnt[i] increments.
  - When the increment would reach DEB_CYCLES: btn_level[i] toggles and cnt[i] returns to 0.
  - Each edge where sync[i] == btn_level[i]: cnt[i] clears to 0. Any glitch shorter than DEB_CYCLES therefore restarts qualification.
- Press acceptance occurs on the rising edge of btn_level[i]. If enable=1, it sets pend[i]=1 with pend_rep[i]=0.
- Auto-repeat applies only when REPEAT_DELAY>0.
  - A per-channel repeat timer loads REPEAT_DELAY on press acceptance.
  - The timer decrements while btn_level[i]=1.
  - On reaching 0, the timer raises a repeat event (pend[i]=1, pend_rep[i]=1) and reloads REPEAT_PERIOD.
  - The timer clears and stops when btn_level[i] falls.
- Release (falling edge of btn_level[i]) never produces an event.
- Arbiter behaviour:
  - Each cycle, the lowest-index channel with pend[i]=1 is issued on the following edge: evt_valid=1, evt_onehot=bit i, evt_repeat=pend_rep[i].
  - pend[i] clears on issue. At most one event per cycle. Other pending channels wait.
- Collision: if a new event for channel i arrives while pend[i] is still 1, the pending entry is kept unchanged, the new event is discarded, and evt_drop pulses for one cycle.
  - An event arriving on the same edge that pend[i] is issued is not a collision. It re-sets pend[i].
- enable=0 behaviour:
  - All pend bits clear immediately (same edge). No new pends are set. evt_valid stays 0.
  - Debounce counters, btn_level and repeat timers keep running.
  - Re-asserting enable with a button already held produces no press event. Repeat events for that held button resume on the timer's next expiry.
- Reset (resetn=0 at any edge, including mid-qualification or mid-repeat):
  - All synchronisers, cnt, btn_level, pend, pend_rep and timers are cleared.
  - Outputs after reset: evt_valid=0, evt_onehot=0, evt_repeat=0, btn_level=0, evt_drop=0.

## Timing
- Press latency:
  - btn_in rises and is first sampled high at edge E0.
  - sync reflects the new level after E1.
  - cnt counts edges E2..E(DEB_CYCLES+1). btn_level and pend set at E(DEB_CYCLES+1).
  - evt_valid is high for the cycle after E(DEB_CYCLES+2). Total: DEB_CYCLES+3 edges with no contention.
- btn_level release latency is likewise DEB_CYCLES+2 edges.
- First repeat: evt_valid REPEAT_DELAY cycles after the press event, then every REPEAT_PERIOD cycles. Contention delays the issue but not the timer phase.
- Contention: k simultaneous pends drain in k consecutive cycles, in ascending index order.
- evt_valid is never high two cycles for the same pend. All outputs are registered.

## Test plan
- Clean press, N_BTN=2, DEB_CYCLES=4, enable=1: btn_in=01 held from E0 -> evt_valid=1, evt_onehot=01, evt_repeat=0 in the cycle after E6, exactly once. btn_level[0]=1 from E5.
- Bounce: btn_in[0] toggles 1,0,1,1,0 every cycle, then holds 1 -> no event during bouncing. Event arrives 7 edges after the final stable rise.
- Simultaneous: both buttons rise on the same edge -> evt_onehot=01, then 10 on the next cycle. evt_drop=0.
- Auto-repeat, REPEAT_DELAY=10, REPEAT_PERIOD=3: hold btn 1 for 25 cycles past acceptance -> press event, then repeats (evt_repeat=1) at +10, +13, +16, +19, +22. None after release.
- enable: hold btn 0 with enable=0 through acceptance, then set enable=1 -> no press event. Drop enable while pend is set -> pend is cleared and no evt_valid.
- Reset mid-qualification (cnt=2) and mid-repeat -> all outputs 0 on the next edge. Press after reset needs the full DEB_CYCLES+3 edges.

Source files
------------

// File: rtl/multi_button_debouncer.sv
// rtl/multi_button_debouncer.sv - N-channel button debouncer with auto-repeat and serialised event bus
module multi_button_debouncer #(
    parameter int N_BTN         = 2,
    parameter int DEB_CYCLES    = 100,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 50
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N_BTN-1:0] i_btn_in,
    input  logic             i_enable,
    output logic             o_evt_valid,
    output logic [N_BTN-1:0] o_evt_onehot,
    output logic             o_evt_repeat,
    output logic [N_BTN-1:0] o_btn_level,
    output logic             o_evt_drop
);

    localparam int CNT_W   = $clog2(DEB_CYCLES + 1);
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] r_level;
    logic [N_BTN-1:0] r_pend;
    logic [N_BTN-1:0] r_pend_rep;
    logic [CNT_W-1:0] r_cnt [N_BTN];
    logic [TMR_W-1:0] r_tmr [N_BTN];

    logic [N_BTN-1:0] w_toggle;
    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] w_rep_evt;
    logic [N_BTN-1:0] w_new;
    logic [N_BTN-1:0] w_issue;
    logic [N_BTN-1:0] w_pend_keep;
    logic [N_BTN-1:0] w_accept;
    logic             w_drop;

    always_comb begin
        w_toggle  = '0;
        w_press   = '0;
        w_rep_evt = '0;
        for (int i = 0; i < N_BTN; i++) begin
            w_toggle[i]  = (r_sync2[i] != r_level[i]) && (r_cnt[i] == CNT_W'(DEB_CYCLES - 1));
            w_press[i]   = w_toggle[i] && !r_level[i];
            w_rep_evt[i] = (REPEAT_DELAY > 0) && r_level[i] && (r_tmr[i] == TMR_W'(1));
        end
        w_new       = (w_press | w_rep_evt) & {N_BTN{i_enable}};
        // Lowest set bit of the pending vector wins arbitration this cycle.
        w_issue     = r_pend & (~r_pend + N_BTN'(1));
        w_pend_keep = r_pend & ~w_issue;
        w_accept    = w_new & ~w_pend_keep;
        w_drop      = |(w_new & w_pend_keep);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_level      <= '0;
            r_pend       <= '0;
            r_pend_rep   <= '0;
            o_evt_valid  <= 1'b0;
            o_evt_onehot <= '0;
            o_evt_repeat <= 1'b0;
            o_evt_drop   <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                r_cnt[i] <= '0;
                r_tmr[i] <= '0;
            end
        end else begin
            r_sync1 <= i_btn_in;
            r_sync2 <= r_sync1;
            for (int i = 0; i < N_BTN; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_toggle[i]) begin
                    r_cnt[i]   <= '0;
                    r_level[i] <= ~r_level[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end

                // Timer runs regardless of enable so repeats keep their phase.
                if (w_press[i]) begin
                    r_tmr[i] <= (REPEAT_DELAY > 0) ? TMR_W'(REPEAT_DELAY) : '0;
                end else if (w_toggle[i]) begin
                    r_tmr[i] <= '0;
                end else if (r_level[i] && (r_tmr[i] != '0)) begin
                    r_tmr[i] <= (r_tmr[i] == TMR_W'(1)) ? TMR_W'(REPEAT_PERIOD) : r_tmr[i] - TMR_W'(1);
                end
            end

            r_pend       <= i_enable ? (w_pend_keep | w_accept) : '0;
            r_pend_rep   <= (r_pend_rep & ~w_accept) | (w_accept & w_rep_evt);
            o_evt_valid  <= i_enable && (|r_pend);
            o_evt_onehot <= i_enable ? w_issue : '0;
            o_evt_repeat <= i_enable && (|(w_issue & r_pend_rep));
            o_evt_drop   <= w_drop;
        end
    end

    assign o_btn_level = r_level;

endmodule

// File: tb/tb_multi_button_debouncer.sv
// tb/tb_multi_button_debouncer.sv - self-checking bench for multi_button_debouncer
module tb_multi_button_debouncer;

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] btn_a, btn_r, btn_d;
    logic       en_a, en_r, en_d;

    logic       a_valid, a_rep, a_drop;
    logic [1:0] a_oh, a_lvl;
    logic       r_valid, r_rep, r_drop;
    logic [1:0] r_oh, r_lvl;
    logic       d_valid, d_rep, d_drop;
    logic [1:0] d_oh, d_lvl;

    logic [6:0] st_a, st_r, st_d;
    assign st_a = {a_valid, a_oh, a_rep, a_lvl, a_drop};
    assign st_r = {r_valid, r_oh, r_rep, r_lvl, r_drop};
    assign st_d = {d_valid, d_oh, d_rep, d_lvl, d_drop};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_button_debouncer #(.N_BTN(2), .DEB_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(50)) dut_a (
        .clk(clk), .resetn(resetn), .i_btn_in(btn_a), .i_enable(en_a),
        .o_evt_valid(a_valid), .o_evt_onehot(a_oh), .o_evt_repeat(a_rep),
        .o_btn_level(a_lvl), .o_evt_drop(a_drop)
    );

    multi_button_debouncer #(.N_BTN(2), .DEB_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) dut_r (
        .clk(clk), .resetn(resetn), .i_btn_in(btn_r), .i_enable(en_r),
        .o_evt_valid(r_valid), .o_evt_onehot(r_oh), .o_evt_repeat(r_rep),
        .o_btn_level(r_lvl), .o_evt_drop(r_drop)
    );

    multi_button_debouncer #(.N_BTN(2), .DEB_CYCLES(1), .REPEAT_DELAY(1), .REPEAT_PERIOD(1)) dut_d (
        .clk(clk), .resetn(resetn), .i_btn_in(btn_d), .i_enable(en_d),
        .o_evt_valid(d_valid), .o_evt_onehot(d_oh), .o_evt_repeat(d_rep),
        .o_btn_level(d_lvl), .o_evt_drop(d_drop)
    );

    typedef struct {
        logic [1:0] btn;
        logic       en;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [6:0] ev(input logic v, input logic [1:0] oh, input logic rep,
                                      input logic [1:0] lvl, input logic drop);
        return {v, oh, rep, lvl, drop};
    endfunction

    task automatic addn(input int n, input logic [1:0] b, input logic e, input logic [6:0] x);
        vec_t v;
        v.btn = b;
        v.en  = e;
        v.exp = x;
        repeat (n) tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] {valid,onehot,repeat,level,drop} got %b expected %b", name, idx, act, exp);
        end
    endtask

    initial begin
        logic [6:0] x;
        logic       v;

        resetn = 1'b0;
        btn_a = 2'b00; btn_r = 2'b00; btn_d = 2'b00;
        en_a = 1'b0; en_r = 1'b0; en_d = 1'b0;
        repeat (3) tick();
        chk("reset_a", 0, st_a, 7'b0);
        chk("reset_r", 0, st_r, 7'b0);
        chk("reset_d", 0, st_d, 7'b0);
        resetn = 1'b1;
        tick();
        tick();

        // clean press / release
        addn(5, 2'b01, 1'b1, ev(0, 2'b00, 0, 2'b00, 0));
        addn(1, 2'b01, 1'b1, ev(0, 2'b00, 0, 2'b01, 0));
        addn(1, 2'b01, 1'b1, ev(1, 2'b01, 0, 2'b01, 0));
        addn(2, 2'b01, 1'b1, ev(0, 2'b00, 0, 2'b01, 0));
        addn(5, 2'b00, 1'b1, ev(0, 2'b00, 0, 2'b01, 0));
        addn(2, 2'b00, 1'b1, ev(0, 2'b00, 0, 2'b00, 0));
        // simultaneous press drains in index order
        addn(5, 2'b11, 1'b1, ev(0, 2'b00, 0, 2'b00, 0));
        addn(1, 2'b11, 1'b1, ev(0, 2'b00, 0, 2'b11, 0));
        addn(1, 2'b11, 1'b1, ev(1, 2'b01, 0, 2'b11, 0));
        addn(1, 2'b11, 1'b1, ev(1, 2'b10, 0, 2'b11, 0));
        addn(2, 2'b11, 1'b1, ev(0, 2'b00, 0, 2'b11, 0));
        addn(5, 2'b00, 1'b1, ev(0, 2'b00, 0, 2'b11, 0));
        addn(2, 2'b00, 1'b1, ev(0, 2'b00, 0, 2'b00, 0));
        // bounce 1,0,1,1,0 then stable high
        addn(1, 2'b01, 1'b1, ev(0, 2'b00, 0, 2'b00, 0));
        addn(1, 2'b00, 1'b1, ev(0, 2'b00, 0, 2'b00, 0));
        addn(2, 2'b01, 1'b1, ev(0, 2'b00, 0, 2'b00, 0));
        addn(1, 2'b00, 1'b1, ev(0, 2'b00, 0, 2'b00, 0));
        addn(5, 2'b01, 1'b1, ev(0, 2'b00, 0, 2'b00, 0));
        addn(1, 2'b01, 1'b1, ev(0, 2'b00, 0, 2'b01, 0));
        addn(1, 2'b01, 1'b1, ev(1, 2'b01, 0, 2'b01, 0));
        addn(2, 2'b01, 1'b1, ev(0, 2'b00, 0, 2'b01, 0));
        addn(5, 2'b00, 1'b1, ev(0, 2'b00, 0, 2'b01, 0));
        addn(2, 2'b00, 1'b1, ev(0, 2'b00, 0, 2'b00, 0));
        // press accepted while disabled, then enabled: no event
        addn(5, 2'b01, 1'b0, ev(0, 2'b00, 0, 2'b00, 0));
        addn(3, 2'b01, 1'b0, ev(0, 2'b00, 0, 2'b01, 0));
        addn(3, 2'b01, 1'b1, ev(0, 2'b00, 0, 2'b01, 0));
        addn(5, 2'b00, 1'b1, ev(0, 2'b00, 0, 2'b01, 0));
        addn(2, 2'b00, 1'b1, ev(0, 2'b00, 0, 2'b00, 0));
        // enable dropped while pend is set
        addn(5, 2'b01, 1'b1, ev(0, 2'b00, 0, 2'b00, 0));
        addn(1, 2'b01, 1'b1, ev(0, 2'b00, 0, 2'b01, 0));
        addn(1, 2'b01, 1'b0, ev(0, 2'b00, 0, 2'b01, 0));
        addn(2, 2'b01, 1'b1, ev(0, 2'b00, 0, 2'b01, 0));
        addn(5, 2'b00, 1'b1, ev(0, 2'b00, 0, 2'b01, 0));
        addn(2, 2'b00, 1'b1, ev(0, 2'b00, 0, 2'b00, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            btn_a = tbl[i].btn;
            en_a  = tbl[i].en;
            tick();
            chk("table", i, st_a, tbl[i].exp);
        end

        // auto-repeat on channel 1, released so the level falls before the next expiry
        en_r = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            btn_r = (k < 24) ? 2'b10 : 2'b00;
            tick();
            v = (k == 6) || (k == 16) || (k == 19) || (k == 22) || (k == 25) || (k == 28);
            x = ev(v, v ? 2'b10 : 2'b00, v && (k != 6), (k >= 5 && k < 29) ? 2'b10 : 2'b00, 0);
            chk("repeat", k, st_r, x);
        end

        // channel 1 starved by back-to-back repeats on channel 0: drops every cycle
        btn_d = 2'b11;
        for (int k = 0; k <= 9; k++) begin
            en_d = (k == 7) ? 1'b0 : 1'b1;
            tick();
            if (k < 2)                 x = ev(0, 2'b00, 0, 2'b00, 0);
            else if (k == 2)           x = ev(0, 2'b00, 0, 2'b11, 0);
            else if (k == 3)           x = ev(1, 2'b01, 0, 2'b11, 1);
            else if (k == 7 || k == 8) x = ev(0, 2'b00, 0, 2'b11, 0);
            else                       x = ev(1, 2'b01, 1, 2'b11, 1);
            chk("drop", k, st_d, x);
        end
        btn_d = 2'b00;
        en_d  = 1'b0;

        // repeat resumes after re-enable; reset mid-repeat and mid-qualification
        en_r = 1'b0;
        btn_r = 2'b01;
        btn_a = 2'b00;
        en_a = 1'b1;
        for (int k = 0; k <= 30; k++) begin
            if (k == 12) en_r = 1'b1;
            if (k == 16) btn_a = 2'b01;
            resetn = (k == 20) ? 1'b0 : 1'b1;
            tick();
            if (k == 20) begin
                chk("rst_mid_a", k, st_a, 7'b0);
                chk("rst_mid_r", k, st_r, 7'b0);
                chk("rst_mid_d", k, st_d, 7'b0);
            end else if (k < 20) begin
                v = (k == 16) || (k == 19);
                chk("resume_r", k, st_r, ev(v, v ? 2'b01 : 2'b00, v, (k >= 5) ? 2'b01 : 2'b00, 0));
                chk("qual_a", k, st_a, 7'b0);
            end else begin
                v = (k == 27);
                x = ev(v, v ? 2'b01 : 2'b00, 0, (k >= 26) ? 2'b01 : 2'b00, 0);
                chk("post_rst_a", k, st_a, x);
                chk("post_rst_r", k, st_r, x);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
